uart_tx_arbiter: RTL and testbench

//  Shares the single 7-bit serial transmitter (load/in/ready handshake) among NREQ character sources.

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 134 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the character sources, the arbiter and the serial transmitter.
// The master modport is the source/transmitter side; the slave modport is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 4
);
  logic [NREQ-1:0]   req_valid;
  logic [7*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   grant;
  logic              tx_load;
  logic [6:0]        tx_data;
  logic              tx_ready;
  logic              busy;

  modport master (
    output req_valid, req_data, tx_ready,
    input  req_ready, grant, tx_load, tx_data, busy
  );

  modport slave (
    input  req_valid, req_data, tx_ready,
    output req_ready, grant, tx_load, tx_data, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one 7-bit serial transmitter among NREQ character sources.
// A granted source keeps the transmitter until it sends LF or idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned LOCK_TIMEOUT = 16'hFFFF,
  parameter bit          LOCK_EN      = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_tx_arbiter_if.slave   bus
);

  localparam int unsigned IdxW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [6:0]  CharLf  = 7'h0A;
  localparam logic [15:0] CntLast = 16'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StSettle, StWait} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   owner_q, owner_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [6:0]        char_q, char_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   cand;
  logic              owner_valid;
  logic [6:0]        owner_char;
  logic              accept;

  // Search last+1, last+2, ... so the previous owner ends up with the lowest priority.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      cand = IdxW'((32'(last_q) + i) % NREQ);
      if (!pick_found && bus.req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    owner_valid = 1'b0;
    owner_char  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (owner_q == IdxW'(i)) begin
        owner_valid = bus.req_valid[i];
        owner_char  = bus.req_data[7*i +: 7];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    char_d  = char_q;
    accept  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          owner_d = pick_idx;
          grant_d = NREQ'(1) << pick_idx;
          cnt_d   = '0;
          state_d = StSend;
        end
      end
      StSend: begin
        if (bus.tx_ready && owner_valid) begin
          accept  = 1'b1;
          char_d  = owner_char;
          cnt_d   = '0;
          state_d = StSettle;
        end else if (!owner_valid) begin
          if (cnt_q == CntLast) begin
            grant_d = '0;
            last_d  = owner_q;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      // One dead cycle so the transmitter can drop tx_ready before we look at it again.
      StSettle: state_d = StWait;
      StWait: begin
        if (bus.tx_ready) begin
          if (!LOCK_EN || (char_q == CharLf)) begin
            grant_d = '0;
            last_d  = owner_q;
            state_d = StIdle;
          end else begin
            cnt_d   = '0;
            state_d = StSend;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IdxW'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      char_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
    end
  end

  assign bus.tx_load   = accept;
  assign bus.tx_data   = accept ? owner_char : 7'h00;
  assign bus.req_ready = accept ? grant_q : '0;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: line lock, timeout and flow control on a locking instance,
// plain round-robin on a non-locking instance.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(4)) bus_a ();
  uart_tx_arbiter_if #(.NREQ(4)) bus_b ();

  uart_tx_arbiter #(.NREQ(4), .LOCK_TIMEOUT(16), .LOCK_EN(1'b1)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  uart_tx_arbiter #(.NREQ(4), .LOCK_TIMEOUT(16'hFFFF), .LOCK_EN(1'b0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [6:0] chars [3] = '{7'h41, 7'h42, 7'h0A};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus_a.req_valid = '0;
    bus_a.req_data  = '0;
    bus_a.tx_ready  = 1'b0;
    bus_b.req_valid = '0;
    bus_b.req_data  = '0;
    bus_b.tx_ready  = 1'b1;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_grant", 32'(bus_a.grant), 32'h0);
    chk("rst_busy", 32'(bus_a.busy), 32'h0);
    chk("rst_tx_load", 32'(bus_a.tx_load), 32'h0);
    chk("rst_req_ready", 32'(bus_a.req_ready), 32'h0);
    cyc(); rst_n = 1'b1;

    // Single char from requester 1
    bus_a.req_data[13:7] = 7'h41;
    bus_a.req_valid      = 4'b0010;
    bus_a.tx_ready       = 1'b1;
    #1 chk("t2_idle_grant", 32'(bus_a.grant), 32'h0);
    cyc(); #1;
    chk("t2_grant", 32'(bus_a.grant), 32'h2);
    chk("t2_tx_load", 32'(bus_a.tx_load), 32'h1);
    chk("t2_tx_data", 32'(bus_a.tx_data), 32'h41);
    chk("t2_req_ready", 32'(bus_a.req_ready), 32'h2);
    cyc();
    bus_a.tx_ready  = 1'b0;
    bus_a.req_valid = 4'b0000;
    #1;
    chk("t2_settle_load", 32'(bus_a.tx_load), 32'h0);
    chk("t2_settle_busy", 32'(bus_a.busy), 32'h1);
    cyc();
    bus_a.tx_ready = 1'b1;
    #1;
    chk("t2_wait_grant", 32'(bus_a.grant), 32'h2);
    chk("t2_wait_load", 32'(bus_a.tx_load), 32'h0);
    cyc(); #1;
    chk("t2_grant_held", 32'(bus_a.grant), 32'h2);

    // Asynchronous reset mid-SEND
    bus_a.req_valid = 4'b0010;
    #1 chk("t1_load_before_rst", 32'(bus_a.tx_load), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_rst_grant", 32'(bus_a.grant), 32'h0);
    chk("t1_rst_tx_load", 32'(bus_a.tx_load), 32'h0);
    chk("t1_rst_req_ready", 32'(bus_a.req_ready), 32'h0);
    chk("t1_rst_busy", 32'(bus_a.busy), 32'h0);
    bus_a.tx_ready = 1'b0;
    cyc(); rst_n = 1'b1;
    cyc(); #1;
    chk("t1_regrant", 32'(bus_a.grant), 32'h2);
    chk("t1_no_load_not_ready", 32'(bus_a.tx_load), 32'h0);
    cyc(); #1;
    chk("t1_no_load_not_ready2", 32'(bus_a.tx_load), 32'h0);
    chk("t1_no_req_ready", 32'(bus_a.req_ready), 32'h0);
    bus_a.tx_ready = 1'b1;
    #1 chk("t1_load_on_ready", 32'(bus_a.tx_load), 32'h1);
    rst_n           = 1'b0;
    bus_a.req_valid = '0;
    cyc(); rst_n = 1'b1;

    // Line lock: requester 0 sends "AB\n" while requester 2 waits
    bus_a.req_data[20:14] = 7'h5A;
    bus_a.req_valid       = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      bus_a.req_data[6:0] = chars[i];
      cyc(); #1;
      chk("t3_grant", 32'(bus_a.grant), 32'h1);
      chk("t3_tx_load", 32'(bus_a.tx_load), 32'h1);
      chk("t3_tx_data", 32'(bus_a.tx_data), 32'(chars[i]));
      chk("t3_req_ready", 32'(bus_a.req_ready), 32'h1);
      cyc();
      bus_a.tx_ready = 1'b0;
      if (i == 2) bus_a.req_valid = 4'b0100;
      #1 chk("t3_settle_ready", 32'(bus_a.req_ready), 32'h0);
      cyc();
      bus_a.tx_ready = 1'b1;
      #1 chk("t3_wait_load", 32'(bus_a.tx_load), 32'h0);
    end
    cyc(); #1;
    chk("t3_released", 32'(bus_a.grant), 32'h0);
    chk("t3_idle_busy", 32'(bus_a.busy), 32'h0);
    cyc(); #1;
    chk("t3_grant2", 32'(bus_a.grant), 32'h4);
    chk("t3_load2", 32'(bus_a.tx_load), 32'h1);
    chk("t3_data2", 32'(bus_a.tx_data), 32'h5A);
    chk("t3_ready2", 32'(bus_a.req_ready), 32'h4);
    rst_n           = 1'b0;
    bus_a.req_valid = '0;
    cyc(); rst_n = 1'b1;

    // Timeout: owner 1 sends 'A' then goes idle, requester 3 waits
    bus_a.req_data[13:7]  = 7'h41;
    bus_a.req_data[27:21] = 7'h33;
    bus_a.req_valid       = 4'b1010;
    cyc(); #1;
    chk("t5_grant", 32'(bus_a.grant), 32'h2);
    chk("t5_data", 32'(bus_a.tx_data), 32'h41);
    cyc();
    bus_a.tx_ready  = 1'b0;
    bus_a.req_valid = 4'b1000;
    cyc();
    bus_a.tx_ready = 1'b1;
    cyc();
    for (int i = 0; i < 16; i++) begin
      #1 chk("t5_hold", 32'(bus_a.grant), 32'h2);
      cyc();
    end
    #1 chk("t5_release", 32'(bus_a.grant), 32'h0);
    cyc(); #1;
    chk("t5_grant3", 32'(bus_a.grant), 32'h8);
    chk("t5_load3", 32'(bus_a.tx_load), 32'h1);
    chk("t5_data3", 32'(bus_a.tx_data), 32'h33);
    chk("t5_ready3", 32'(bus_a.req_ready), 32'h8);

    // Flow control: transmitter stays busy for 500 cycles
    cyc();
    bus_a.tx_ready        = 1'b0;
    bus_a.req_data[27:21] = 7'h34;
    for (int i = 0; i < 500; i++) begin
      #1 chk("t6_stall", 32'({bus_a.tx_load, bus_a.req_ready, bus_a.busy}), 32'h01);
      cyc();
    end
    bus_a.tx_ready = 1'b1;
    #1 chk("t6_wait_load", 32'(bus_a.tx_load), 32'h0);
    cyc(); #1;
    chk("t6_load", 32'(bus_a.tx_load), 32'h1);
    chk("t6_data", 32'(bus_a.tx_data), 32'h34);
    chk("t6_ready", 32'(bus_a.req_ready), 32'h8);

    // Round-robin without lock on the second instance
    bus_b.req_data  = {7'h33, 7'h32, 7'h31, 7'h30};
    bus_b.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      cyc(); #1;
      chk("t4_grant", 32'(bus_b.grant), 32'(1 << (i % 4)));
      chk("t4_load", 32'(bus_b.tx_load), 32'h1);
      chk("t4_data", 32'(bus_b.tx_data), 32'(8'h30 + (i % 4)));
      chk("t4_ready", 32'(bus_b.req_ready), 32'(1 << (i % 4)));
      cyc(); cyc(); cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
